// File: rtl/sp_ram_rw_ctrl.sv
// Initiator for a single-port BRAM: arbitrates write and read request streams onto
// the one port and returns read data through a 2-entry registered buffer.
module sp_ram_rw_ctrl #(
  parameter int G_ADDR  = 6,
  parameter int G_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_vld,
  input  logic [G_ADDR-1:0]  wr_addr,
  input  logic [G_WIDTH-1:0] wr_data,
  output logic               wr_rdy,
  input  logic               rd_vld,
  input  logic [G_ADDR-1:0]  rd_addr,
  output logic               rd_rdy,
  output logic               rdat_vld,
  output logic [G_WIDTH-1:0] rdat,
  input  logic               rdat_rdy,
  output logic               ram_we,
  output logic [G_ADDR-1:0]  ram_addr,
  output logic [G_WIDTH-1:0] ram_din,
  input  logic [G_WIDTH-1:0] ram_dout
);

  typedef enum logic {PRI_WR, PRI_RD} pri_t;

  pri_t               pri_q, pri_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               infl_q;
  logic [G_ADDR-1:0]  addr_q;
  logic [G_WIDTH-1:0] b0_q, b1_q;
  logic               v0_q, v1_q;

  logic pop, rd_ok, gnt_wr, gnt_rd;

  // Grants are gated by rst_n so the RAM sees no write while reset is asserted.
  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    pri_d  = pri_q;
    pop    = v0_q & rdat_rdy;
    rd_ok  = rd_vld & ((cnt_q != 2'd2) | pop);
    if (rst_n) begin
      if (wr_vld & rd_ok) begin
        if (pri_q == PRI_WR) begin
          gnt_wr = 1'b1;
          pri_d  = PRI_RD;
        end else begin
          gnt_rd = 1'b1;
          pri_d  = PRI_WR;
        end
      end else begin
        gnt_wr = wr_vld;
        gnt_rd = rd_ok;
      end
    end
    cnt_d = cnt_q + 2'(gnt_rd) - 2'(pop);
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_din  = '0;
    if (gnt_wr) begin
      ram_we   = 1'b1;
      ram_addr = wr_addr;
      ram_din  = wr_data;
    end else if (gnt_rd) begin
      ram_addr = rd_addr;
    end
  end

  assign wr_rdy   = gnt_wr;
  assign rd_rdy   = gnt_rd;
  assign rdat_vld = v0_q;
  assign rdat     = b0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q  <= PRI_WR;
      cnt_q  <= '0;
      infl_q <= 1'b0;
      addr_q <= '0;
    end else begin
      pri_q  <= pri_d;
      cnt_q  <= cnt_d;
      infl_q <= gnt_rd;
      if (gnt_wr | gnt_rd) addr_q <= ram_addr;
    end
  end

  // Return buffer: b0 is the head presented on rdat; ram_dout is sampled only in
  // the cycle right after a read grant (infl_q).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0_q <= '0;
      b1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else if (infl_q & pop) begin
      if (v1_q) begin
        b0_q <= b1_q;
        b1_q <= ram_dout;
      end else begin
        b0_q <= ram_dout;
      end
    end else if (pop) begin
      if (v1_q) b0_q <= b1_q;
      v0_q <= v1_q;
      v1_q <= 1'b0;
    end else if (infl_q) begin
      if (!v0_q) begin
        b0_q <= ram_dout;
        v0_q <= 1'b1;
      end else begin
        b1_q <= ram_dout;
        v1_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sp_ram_rw_ctrl.sv
// Bench for sp_ram_rw_ctrl: behavioural BRAM plus a queue-based reference model,
// directed scenarios followed by randomized traffic with occasional resets.
module tb_sp_ram_rw_ctrl;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_vld, rd_vld, rdat_rdy;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_rdy, rd_rdy, rdat_vld, ram_we;
  logic [DW-1:0] rdat, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  sp_ram_rw_ctrl #(.G_ADDR(AW), .G_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_vld(rd_vld), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .rdat_vld(rdat_vld), .rdat(rdat), .rdat_rdy(rdat_rdy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port BRAM: 1-cycle registered read, dout unchanged on write.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    else        ram_dout <= ram[ram_addr];
  end

  // Reference model state
  typedef struct {
    logic [DW-1:0] d;
    int unsigned   t;
  } rd_item_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rd_item_t      q[$];
  bit            ref_pri_rd;
  logic [AW-1:0] ref_last;
  int unsigned   cyc;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs, check the DUT against the model, then advance the model.
  task automatic step(input bit rst, input bit wv, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input bit rv, input logic [AW-1:0] ra,
                      input bit rr);
    bit e_vld, e_pop, e_rdok, e_gw, e_gr;
    logic [AW-1:0] e_addr;
    @(posedge clk);
    #1;
    rst_n = rst; wr_vld = wv; wr_addr = wa; wr_data = wd;
    rd_vld = rv; rd_addr = ra; rdat_rdy = rr;
    if (!rst) begin
      q.delete();
      ref_pri_rd = 1'b0;
      ref_last   = '0;
    end
    @(negedge clk);
    e_vld  = (q.size() > 0) && (q[0].t <= cyc);
    e_pop  = e_vld && rr;
    e_rdok = rv && ((q.size() < 2) || e_pop);
    e_gw = 1'b0;
    e_gr = 1'b0;
    if (rst) begin
      if (wv && e_rdok) begin
        e_gw = !ref_pri_rd;
        e_gr = ref_pri_rd;
        ref_pri_rd = !ref_pri_rd;
      end else begin
        e_gw = wv;
        e_gr = e_rdok;
      end
    end
    e_addr = e_gw ? wa : (e_gr ? ra : ref_last);
    chk("wr_rdy",   32'(wr_rdy),   32'(e_gw));
    chk("rd_rdy",   32'(rd_rdy),   32'(e_gr));
    chk("ram_we",   32'(ram_we),   32'(e_gw));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (e_gw) chk("ram_din", 32'(ram_din), 32'(wd));
    chk("rdat_vld", 32'(rdat_vld), 32'(e_vld));
    if (e_vld) chk("rdat", 32'(rdat), 32'(q[0].d));
    if (e_pop) void'(q.pop_front());
    if (e_gw) ref_mem[wa] = wd;
    if (e_gr) q.push_back('{d: ref_mem[ra], t: cyc + 2});
    if (e_gw || e_gr) ref_last = e_addr;
    chk("credits_le2", 32'(q.size() <= 2), 32'd1);
    cyc++;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, rr);
  endtask

  initial begin
    logic [DW-1:0] v;
    cyc = 0;
    ref_pri_rd = 1'b0;
    ref_last = '0;
    rst_n = 1'b0; wr_vld = 1'b0; rd_vld = 1'b0; rdat_rdy = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      v = DW'($urandom);
      ram[i] = v;
      ref_mem[i] = v;
    end

    // Reset with both requests pending, then first grant must be the write
    step(1'b0, 1'b1, 6'd3, 16'h5555, 1'b1, 6'd4, 1'b1);
    step(1'b0, 1'b1, 6'd3, 16'h5555, 1'b1, 6'd4, 1'b1);
    step(1'b1, 1'b1, 6'd3, 16'h5555, 1'b1, 6'd4, 1'b1);
    idle(3, 1'b1);

    // Write then read-after-write
    step(1'b1, 1'b1, 6'd5, 16'h1234, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b1, 6'd5, 1'b1);
    idle(3, 1'b1);

    // Contention from a fresh reset: W,R,W,R
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 6'(10 + i), 16'(16'hC0 + i), 1'b1, 6'(i), 1'b1);
    idle(3, 1'b1);

    // Backpressure: only two reads accepted until a pop frees a credit
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6'(i), 16'(16'hA0 + i), 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b1, 6'd0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b1, 6'd1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, '0, 1'b1, 6'd2, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b1, 6'd2, 1'b1);
    idle(4, 1'b1);

    // Streaming 8 reads
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, '0, 1'b1, 6'(i), 1'b1);
    idle(4, 1'b1);

    // Reset right after a read accept discards it
    step(1'b1, 1'b0, '0, '0, 1'b1, 6'd7, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle(4, 1'b1);
    step(1'b1, 1'b1, 6'd5, 16'hBEEF, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b1, 6'd5, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(99) != 0), $urandom_range(1) == 1, 6'($urandom_range(7)),
           16'($urandom), $urandom_range(1) == 1, 6'($urandom_range(7)),
           $urandom_range(9) < 7);
    idle(4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sp_ram_rw_ctrl.md
Name: sp_ram_rw_ctrl

Overview:
- Initiator side of the single-port block-RAM interface (we/addr/din/dout, 1-cycle registered read, no-change on write).
- Accepts independent write and read request streams (valid/ready) and arbitrates them onto the one RAM port.
- Captures RAM read data into a 2-entry return buffer and presents it on a valid/ready read-data stream.
- Sits between client logic and an instance of the team's single-port BRAM macro, with matching parameters.

Parameters:
G_ADDR, 6, address width; RAM depth = 2**G_ADDR
G_WIDTH, 16, data width

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_vld  input  1  write request valid
wr_addr  input  G_ADDR  write address
wr_data  input  G_WIDTH  write data
wr_rdy  output  1  write accepted this cycle when wr_vld&wr_rdy
rd_vld  input  1  read request valid
rd_addr  input  G_ADDR  read address
rd_rdy  output  1  read accepted this cycle when rd_vld&rd_rdy
rdat_vld  output  1  read data valid
rdat  output  G_WIDTH  read data
rdat_rdy  input  1  consumer ready; pop when rdat_vld&rdat_rdy
ram_we  output  1  to RAM we
ram_addr  output  G_ADDR  to RAM addr
ram_din  output  G_WIDTH  to RAM din
ram_dout  input  G_WIDTH  from RAM dout

Behaviour:
- Reset (rst_n low, async): rdat_vld=0, rdat=0, buffer empty, credit count=0, in-flight flag=0, priority pointer=write. wr_rdy, rd_rdy and ram_we forced 0 while rst_n low.
- Credit count C (0..2) = reads accepted and not yet popped (in flight + buffered).
- rd_ok = rd_vld & (C<2 | pop this cycle).
- Arbitration, combinational, each cycle:
  - wr_vld only -> grant write.
  - rd_ok only -> grant read.
  - both -> grant the side indicated by the priority pointer; the pointer flips to the other side after every contested grant. Uncontested grants leave the pointer unchanged.
  - rd_vld with rd_ok=0 counts as no read request, so a pending write proceeds.
- wr_rdy/rd_rdy depend on wr_vld/rd_vld. At most one of them is high per cycle.
- RAM drive, combinational:
  - Write grant: ram_we=1, ram_addr=wr_addr, ram_din=wr_data.
  - Read grant: ram_we=0, ram_addr=rd_addr.
  - Idle: ram_we=0, ram_addr holds the last granted address (registered copy), ram_din=don't-care (driven 0).
- Read latency:
  - Read accepted in cycle N; ram_dout valid in N+1 and captured into the buffer at the end of N+1.
  - rdat_vld=1 earliest in cycle N+2.
  - Only the cycle N+1 ram_dout is sampled. No-change hold of dout during writes is never relied on.
- Return buffer:
  - 2-entry FIFO with registered outputs; rdat/rdat_vld come from the head register.
  - Data order equals read-acceptance order.
  - rdat is stable while rdat_vld=1 & rdat_rdy=0.
- Throughput:
  - With rdat_rdy held 1, back-to-back reads are accepted every cycle, because a pop frees a credit in the same cycle.
  - With rdat_rdy=0, at most 2 reads are accepted, then rd_rdy stays 0 until a pop.
- Read-after-write: a write accepted in N followed by a read of the same address accepted in N+1 or later returns the new data. No hazard logic is needed (single port, in order).
- Simultaneous capture and pop: occupancy is unchanged. C updates as +1 on accept and -1 on pop; both in one cycle leave C unchanged.
- Overflow cannot occur by construction. The bench asserts that capture into a full buffer with no pop never happens.
- Reset mid-operation: in-flight read is discarded, buffer is cleared, C=0. No rdat_vld pulse after reset release until a new read completes.

Test Plan:
- Reset: hold rst_n=0 with wr_vld=rd_vld=1 -> wr_rdy=rd_rdy=ram_we=0, rdat_vld=0. Release -> first grant is write.
- Write 0x1234@5, then read @5 next cycle, rdat_rdy=1 -> read accepted cycle 1, rdat_vld=1 with rdat=0x1234 in cycle 3.
- Contention: wr_vld and rd_vld held for 4 cycles, rdat_rdy=1 -> grants alternate W,R,W,R; ram_we pattern 1,0,1,0.
- Backpressure: rdat_rdy=0, reads @0,@1,@2 of 0xA0,0xA1,0xA2 -> only 2 accepted; rd_rdy=0 until rdat_rdy=1. Data is popped 0xA0,0xA1,0xA2 in order, rdat stable while stalled.
- Streaming: 8 back-to-back reads @0..7 with rdat_rdy=1 -> rd_rdy stays 1, 8 consecutive rdat_vld cycles starting 2 cycles after the first accept, correct data.
- Reset asserted the cycle after a read accept -> after release rdat_vld stays 0 and C=0; the next read behaves as in scenario 2.
